// File: rtl/addr_seq_if.sv
// rtl/addr_seq_if.sv - memory bus interface between addr_seq and its memory
// Purpose: groups the memory access handshake of the address sequencer.
// Signals:
//   mem_addr     master->slave  access address
//   mem_we       master->slave  write strobe
//   mem_wr_data  master->slave  write data
//   mem_rd_data  slave->master  read data for the current mem_addr
//   mem_ready    slave->master  access accepted this cycle
interface addr_seq_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          mem_ready;
  logic          mem_we;
  logic [DW-1:0] mem_wr_data;

  modport master (
    output mem_addr, mem_we, mem_wr_data,
    input  mem_rd_data, mem_ready
  );

  modport slave (
    input  mem_addr, mem_we, mem_wr_data,
    output mem_rd_data, mem_ready
  );
endinterface

// File: rtl/addr_seq.sv
// rtl/addr_seq.sv - operand address sequencer for 6502-style addressing modes
// Purpose: walks the operand-fetch / effective-address / read-modify-write
//   cycles for one instruction and reports ea, operand and pc_next.
// Optional feature: define ADDR_SEQ_PAGE_CROSS_EN to insert a FIX cycle for
//   indexed absolute modes when lo+idx carries (and always for ABSX with rmw).
// Ports:
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   start, mode, rmw       sequence request, sampled only in IDLE
//   pc, idx                opcode address, index value
//   wb_data                modified value written back in MWR
//   mem                    memory bus (addr_seq_if.master)
//   ea, operand, pc_next   results, valid with done, held until next start
//   busy, done, err        in-sequence, completion pulse, illegal pulse
module addr_seq #(
  parameter int AW = 16,
  parameter int DW = 8    // AW must equal 2*DW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic          rmw,
  input  logic [AW-1:0] pc,
  input  logic [DW-1:0] idx,
  input  logic [DW-1:0] wb_data,
  addr_seq_if.master    mem,
  output logic [AW-1:0] ea,
  output logic [DW-1:0] operand,
  output logic [AW-1:0] pc_next,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_OPL, S_OPH, S_IDX, S_FIX, S_RD, S_MWD, S_MWR
  } state_t;

  localparam logic [2:0] M_IMP  = 3'd0;
  localparam logic [2:0] M_IMM  = 3'd1;
  localparam logic [2:0] M_ZP   = 3'd2;
  localparam logic [2:0] M_ZPX  = 3'd3;
  localparam logic [2:0] M_ABS  = 3'd4;
  localparam logic [2:0] M_ABSX = 3'd5;
  localparam logic [2:0] M_ABSY = 3'd6;
  localparam logic [2:0] M_ILL  = 3'd7;

  state_t        state;
  logic [2:0]    mode_q;
  logic          rmw_q;
  logic [AW-1:0] pc_q;
  logic [DW-1:0] idx_q;
  logic [DW-1:0] lo_q;
  logic [DW-1:0] wr_q;
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;

  logic          illegal;
  logic [DW-1:0] lo_sum;
  logic [AW-1:0] zp_addr;
  logic [AW-1:0] abs_base;
  logic [AW-1:0] abs_idx;
  logic          fix_need;

  assign illegal  = (mode == M_ILL) ||
                    (rmw && (mode == M_IMP || mode == M_IMM || mode == M_ABSY));
  // Low-byte sum wraps within the page; used for ZPX ea and the FIX address.
  assign lo_sum   = lo_q + idx_q;
  assign zp_addr  = {{(AW-DW){1'b0}}, mem.mem_rd_data};
  // Valid in OPH: the high byte is on mem_rd_data, the low byte is in lo_q.
  assign abs_base = {mem.mem_rd_data, lo_q};
  assign abs_idx  = abs_base + AW'(idx_q);

`ifdef ADDR_SEQ_PAGE_CROSS_EN
  // A carry out of lo+idx shows up as a changed high byte.
  assign fix_need = (abs_idx[AW-1:DW] != mem.mem_rd_data) ||
                    (mode_q == M_ABSX && rmw_q);
`else
  assign fix_need = 1'b0;
`endif

  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_we      = mem_we_q;
  // MWR drives the write-back value presented during that cycle; the caller
  // holds wb_data stable while MWR is stalled.
  assign mem.mem_wr_data = (state == S_MWR) ? wb_data : wr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      mode_q     <= '0;
      rmw_q      <= 1'b0;
      pc_q       <= '0;
      idx_q      <= '0;
      lo_q       <= '0;
      wr_q       <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      ea         <= '0;
      operand    <= '0;
      pc_next    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            rmw_q  <= rmw;
            pc_q   <= pc;
            idx_q  <= idx;
            if (illegal) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (mode == M_IMP) begin
              pc_next <= pc + AW'(1);
              ea      <= '0;
              operand <= '0;
              done    <= 1'b1;
            end else begin
              ea         <= (mode == M_IMM) ? pc + AW'(1) : '0;
              operand    <= '0;
              pc_next    <= (mode == M_IMM || mode == M_ZP || mode == M_ZPX) ?
                            pc + AW'(2) : pc + AW'(3);
              mem_addr_q <= pc + AW'(1);
              busy       <= 1'b1;
              state      <= S_OPL;
            end
          end
        end

        S_OPL: begin
          if (mem.mem_ready) begin
            lo_q <= mem.mem_rd_data;
            case (mode_q)
              M_IMM: begin
                operand <= mem.mem_rd_data;
                busy    <= 1'b0;
                done    <= 1'b1;
                state   <= S_IDLE;
              end
              M_ZP: begin
                ea         <= zp_addr;
                mem_addr_q <= zp_addr;
                state      <= S_RD;
              end
              M_ZPX: begin
                // Dummy read of the unindexed zero-page address.
                mem_addr_q <= zp_addr;
                state      <= S_IDX;
              end
              default: begin
                mem_addr_q <= pc_q + AW'(2);
                state      <= S_OPH;
              end
            endcase
          end
        end

        S_OPH: begin
          if (mem.mem_ready) begin
            ea <= (mode_q == M_ABS) ? abs_base : abs_idx;
            if (mode_q != M_ABS && fix_need) begin
              // Read from the uncorrected page before the real access.
              mem_addr_q <= {mem.mem_rd_data, lo_sum};
              state      <= S_FIX;
            end else begin
              mem_addr_q <= (mode_q == M_ABS) ? abs_base : abs_idx;
              state      <= S_RD;
            end
          end
        end

        S_IDX: begin
          if (mem.mem_ready) begin
            ea         <= {{(AW-DW){1'b0}}, lo_sum};
            mem_addr_q <= {{(AW-DW){1'b0}}, lo_sum};
            state      <= S_RD;
          end
        end

        S_FIX: begin
          if (mem.mem_ready) begin
            mem_addr_q <= ea;
            state      <= S_RD;
          end
        end

        S_RD: begin
          if (mem.mem_ready) begin
            operand <= mem.mem_rd_data;
            if (rmw_q) begin
              wr_q     <= mem.mem_rd_data;
              mem_we_q <= 1'b1;
              state    <= S_MWD;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end

        S_MWD: begin
          if (mem.mem_ready) begin
            state <= S_MWR;
          end
        end

        S_MWR: begin
          if (mem.mem_ready) begin
            mem_we_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_IDLE;
          end
        end

        default: begin
          mem_we_q <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_seq.sv
// tb/tb_addr_seq.sv - scoreboard testbench for addr_seq
module tb_addr_seq;

`ifdef ADDR_SEQ_PAGE_CROSS_EN
  localparam int XC = 1;
`else
  localparam int XC = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [2:0]  mode;
  logic        rmw;
  logic [15:0] pc;
  logic [7:0]  idx;
  logic [7:0]  wb_data;
  logic [15:0] ea;
  logic [7:0]  operand;
  logic [15:0] pc_next;
  logic        busy;
  logic        done;
  logic        err;

  addr_seq_if #(.AW(16), .DW(8)) m ();

  addr_seq #(.AW(16), .DW(8)) dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode), .rmw(rmw),
    .pc(pc), .idx(idx), .wb_data(wb_data), .mem(m), .ea(ea),
    .operand(operand), .pc_next(pc_next), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tb_mem [65536];
  assign m.mem_rd_data = tb_mem[m.mem_addr];
  always @(posedge clk)
    if (resetn && busy && m.mem_we && m.mem_ready) tb_mem[m.mem_addr] = m.mem_wr_data;

  typedef struct {
    string       nm;
    int          t0;
    int          lat;
    bit          err;
    bit          vals;
    logic [15:0] ea;
    logic [7:0]  op;
    logic [15:0] pcn;
  } exp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  data;
  } acc_t;

  exp_t exp_q[$];
  acc_t acc_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endfunction

  function automatic exp_t mk(string nm, int lat, bit e, bit vals,
                              logic [15:0] ea_v, logic [7:0] op_v, logic [15:0] pcn_v);
    exp_t r;
    r.nm = nm; r.t0 = 0; r.lat = lat; r.err = e; r.vals = vals;
    r.ea = ea_v; r.op = op_v; r.pcn = pcn_v;
    return r;
  endfunction

  task automatic push_acc(input logic [15:0] a, input logic we, input logic [7:0] d);
    acc_t x;
    x.addr = a; x.we = we; x.data = d;
    acc_q.push_back(x);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that sampled start.
  task automatic start_seq(input logic [2:0] md, input logic r, input logic [15:0] p,
                           input logic [7:0] ix, input exp_t e);
    exp_t x;
    x = e;
    mode = md; rmw = r; pc = p; idx = ix; start = 1'b1;
    x.t0 = cyc;
    exp_q.push_back(x);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_done_seen"}, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Completion monitor: pops one expected result per done pulse.
  always @(negedge clk) begin
    if (resetn && done) begin
      chk("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.nm, "_latency"}, cyc - e.t0, e.lat);
        chk({e.nm, "_err"}, {31'd0, err}, {31'd0, e.err});
        if (e.vals) begin
          chk({e.nm, "_ea"}, {16'd0, ea}, {16'd0, e.ea});
          chk({e.nm, "_operand"}, {24'd0, operand}, {24'd0, e.op});
          chk({e.nm, "_pc_next"}, {16'd0, pc_next}, {16'd0, e.pcn});
        end
      end
    end
  end

  // Access monitor: every accepted memory access is matched in order.
  always @(negedge clk) begin
    if (resetn && busy && m.mem_ready) begin
      chk("access_expected", {31'd0, acc_q.size() != 0}, 32'd1);
      if (acc_q.size() != 0) begin
        acc_t a;
        a = acc_q.pop_front();
        chk("access_addr", {16'd0, m.mem_addr}, {16'd0, a.addr});
        chk("access_we", {31'd0, m.mem_we}, {31'd0, a.we});
        if (a.we) chk("access_wdata", {24'd0, m.mem_wr_data}, {24'd0, a.data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    start = 1'b0; mode = 3'd0; rmw = 1'b0; pc = 16'h0; idx = 8'h0;
    wb_data = 8'h00; m.mem_ready = 1'b1; resetn = 1'b0;
    for (int i = 0; i < 65536; i++) tb_mem[i] = 8'h00;
    tb_mem[16'h0000] = 8'h5A;
    tb_mem[16'h0301] = 8'hFF; tb_mem[16'h0001] = 8'h77;
    tb_mem[16'h0201] = 8'hF0; tb_mem[16'h0202] = 8'h12; tb_mem[16'h1310] = 8'h3C;
    tb_mem[16'h0011] = 8'h10; tb_mem[16'h0010] = 8'h41;
    tb_mem[16'h4001] = 8'h34; tb_mem[16'h4002] = 8'h56; tb_mem[16'h5634] = 8'h99;
    tb_mem[16'h4101] = 8'h10; tb_mem[16'h4102] = 8'h20; tb_mem[16'h2015] = 8'hAB;
    tb_mem[16'h4201] = 8'hFF; tb_mem[16'h4202] = 8'hFF;
    tb_mem[16'h4301] = 8'h00; tb_mem[16'h4302] = 8'h60; tb_mem[16'h6000] = 8'h11;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_mem_we", {31'd0, m.mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, m.mem_addr}, 32'd0);
    chk("rst_mem_wr_data", {24'd0, m.mem_wr_data}, 32'd0);
    chk("rst_ea", {16'd0, ea}, 32'd0);
    chk("rst_operand", {24'd0, operand}, 32'd0);
    chk("rst_pc_next", {16'd0, pc_next}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // IMP: no access, done one cycle after start
    start_seq(3'd0, 1'b0, 16'h1234, 8'h00, mk("imp", 1, 0, 1, 16'h0000, 8'h00, 16'h1235));
    wait_done("imp");

    // IMM at pc=0xFFFF with three stalled OPL cycles
    m.mem_ready = 1'b0;
    push_acc(16'h0000, 1'b0, 8'h00);
    start_seq(3'd1, 1'b0, 16'hFFFF, 8'h00, mk("imm_stall", 5, 0, 1, 16'h0000, 8'h5A, 16'h0001));
    chk("imm_stall_addr_c1", {16'd0, m.mem_addr}, 32'h0000);
    chk("imm_stall_busy_c1", {31'd0, busy}, 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("imm_stall_addr_held", {16'd0, m.mem_addr}, 32'h0000);
      chk("imm_stall_we_held", {31'd0, m.mem_we}, 32'd0);
    end
    @(posedge clk); #1;
    m.mem_ready = 1'b1;
    wait_done("imm_stall");

    // ZPX with page-zero wrap
    push_acc(16'h0301, 1'b0, 8'h00);
    push_acc(16'h00FF, 1'b0, 8'h00);
    push_acc(16'h0001, 1'b0, 8'h00);
    start_seq(3'd3, 1'b0, 16'h0300, 8'h02, mk("zpx", 4, 0, 1, 16'h0001, 8'h77, 16'h0302));
    wait_done("zpx");

    // ABSX crossing a page
    push_acc(16'h0201, 1'b0, 8'h00);
    push_acc(16'h0202, 1'b0, 8'h00);
    if (XC == 1) push_acc(16'h1210, 1'b0, 8'h00);
    push_acc(16'h1310, 1'b0, 8'h00);
    start_seq(3'd5, 1'b0, 16'h0200, 8'h20, mk("absx", 4 + XC, 0, 1, 16'h1310, 8'h3C, 16'h0203));
    wait_done("absx");

    // ZP read-modify-write
    wb_data = 8'h82;
    push_acc(16'h0011, 1'b0, 8'h00);
    push_acc(16'h0010, 1'b0, 8'h00);
    push_acc(16'h0010, 1'b1, 8'h41);
    push_acc(16'h0010, 1'b1, 8'h82);
    start_seq(3'd2, 1'b1, 16'h0010, 8'h00, mk("zp_rmw", 5, 0, 1, 16'h0010, 8'h41, 16'h0012));
    wait_done("zp_rmw");
    chk("zp_rmw_mem", {24'd0, tb_mem[16'h0010]}, 32'h82);

    // ABS
    push_acc(16'h4001, 1'b0, 8'h00);
    push_acc(16'h4002, 1'b0, 8'h00);
    push_acc(16'h5634, 1'b0, 8'h00);
    start_seq(3'd4, 1'b0, 16'h4000, 8'h77, mk("abs", 4, 0, 1, 16'h5634, 8'h99, 16'h4003));
    wait_done("abs");

    // ABSY without a page crossing
    push_acc(16'h4101, 1'b0, 8'h00);
    push_acc(16'h4102, 1'b0, 8'h00);
    push_acc(16'h2015, 1'b0, 8'h00);
    start_seq(3'd6, 1'b0, 16'h4100, 8'h05, mk("absy", 4, 0, 1, 16'h2015, 8'hAB, 16'h4103));
    wait_done("absy");

    // ABSY wrapping past 0xFFFF
    push_acc(16'h4201, 1'b0, 8'h00);
    push_acc(16'h4202, 1'b0, 8'h00);
    if (XC == 1) push_acc(16'hFF00, 1'b0, 8'h00);
    push_acc(16'h0000, 1'b0, 8'h00);
    start_seq(3'd6, 1'b0, 16'h4200, 8'h01, mk("absy_wrap", 4 + XC, 0, 1, 16'h0000, 8'h5A, 16'h4203));
    wait_done("absy_wrap");

    // Illegal requests
    start_seq(3'd7, 1'b0, 16'h5000, 8'h00, mk("ill_mode7", 1, 1, 0, 16'h0, 8'h0, 16'h0));
    wait_done("ill_mode7");
    start_seq(3'd1, 1'b1, 16'h5000, 8'h00, mk("ill_imm_rmw", 1, 1, 0, 16'h0, 8'h0, 16'h0));
    wait_done("ill_imm_rmw");
    start_seq(3'd6, 1'b1, 16'h5000, 8'h00, mk("ill_absy_rmw", 1, 1, 0, 16'h0, 8'h0, 16'h0));
    wait_done("ill_absy_rmw");

    // ABS rmw aborted by reset during a stalled MWD
    push_acc(16'h4301, 1'b0, 8'h00);
    push_acc(16'h4302, 1'b0, 8'h00);
    push_acc(16'h6000, 1'b0, 8'h00);
    mode = 3'd4; rmw = 1'b1; pc = 16'h4300; idx = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    m.mem_ready = 1'b0;
    chk("mwd_we_high", {31'd0, m.mem_we}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("abort_we_low", {31'd0, m.mem_we}, 32'd0);
    chk("abort_busy_low", {31'd0, busy}, 32'd0);
    chk("abort_mem_addr", {16'd0, m.mem_addr}, 32'd0);
    chk("abort_wr_data", {24'd0, m.mem_wr_data}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    m.mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("abort_mem_untouched", {24'd0, tb_mem[16'h6000]}, 32'h11);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    start_seq(3'd7, 1'b0, 16'h0000, 8'h00, mk("post_rst_ill", 1, 1, 0, 16'h0, 8'h0, 16'h0));
    wait_done("post_rst_ill");

    repeat (3) @(posedge clk);
    #1;
    chk("exp_queue_empty", exp_q.size(), 32'd0);
    chk("acc_queue_empty", acc_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
